// File: rtl/codec_init_sequencer.sv
// Codec init sequencer: power-up delay, then one I2C write per table entry to the audio codec.
// Build with INIT_TIMEOUT_EN defined to add the per-command watchdog and the ERROR state.
module codec_init_sequencer #(
    parameter logic [7:0]  SLAVE_ADDR     = 8'h35,
    parameter int unsigned NUM_CMDS       = 8,
    parameter int unsigned POWERUP_CYCLES = 1_000_000,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       osc_clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       i2c_free,
    output logic       i2c_en,
    output logic [7:0] i2c_slave_addr,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] cmd_idx
);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [31:0] PU_LOAD  = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_CMDS - 1);

    if (NUM_CMDS < 1 || NUM_CMDS > 16 || POWERUP_CYCLES < 1 || GAP_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("codec_init_sequencer: parameter out of range");
    end

    // Register/data pairs; slots past the populated table read as zero.
    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return {8'h1E, 8'h00};
            4'd1:    return {8'h19, 8'hC0};
            4'd2:    return {8'h1A, 8'hF8};
            4'd3:    return {8'h07, 8'h02};
            4'd4:    return {8'h08, 8'h00};
            4'd5:    return {8'h05, 8'h00};
            4'd6:    return {8'h0A, 8'hFF};
            4'd7:    return {8'h0B, 8'hFF};
            default: return 16'h0000;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        en_q, en_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_d;
`ifdef INIT_TIMEOUT_EN
    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);
    logic [31:0] wd_q, wd_d;
    logic        err_q;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        en_d    = 1'b0;
`ifdef INIT_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_POWERUP: begin
                if (cnt_q == '0) state_d = S_ISSUE;
                else             cnt_d   = cnt_q - 32'd1;
            end
            S_ISSUE: begin
                if (i2c_free) begin
                    en_d    = 1'b1;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!i2c_free) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i2c_free) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_ISSUE;
                    idx_d   = idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_ISSUE;
                    idx_d   = 4'd0;
                end
            end
            default: state_d = S_POWERUP;
        endcase
`ifdef INIT_TIMEOUT_EN
        // Watchdog spans both wait states; only a free rise in WAIT_DONE ends the command normally.
        if (state_q == S_ISSUE) begin
            wd_d = '0;
        end else if (state_q == S_WAIT_ACK || (state_q == S_WAIT_DONE && !i2c_free)) begin
            if (wd_q == WD_LIMIT) state_d = S_ERROR;
            else                  wd_d    = wd_q + 32'd1;
        end
`endif
        // Status flags and table outputs are registered from the next state so they track it exactly.
        busy_d          = (state_d != S_DONE) && (state_d != S_ERROR);
        done_d          = (state_d == S_DONE);
        err_d           = (state_d == S_ERROR);
        {reg_d, data_d} = table_entry(idx_d);
    end

    // NOTE: clocked state uses non-blocking assignments only.
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_POWERUP;
            cnt_q   <= PU_LOAD;
            idx_q   <= 4'd0;
            en_q    <= 1'b0;
            reg_q   <= 8'h1E;
            data_q  <= 8'h00;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef INIT_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef INIT_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign i2c_en         = en_q;
    assign i2c_slave_addr = SLAVE_ADDR;
    assign i2c_reg        = reg_q;
    assign i2c_data       = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cmd_idx        = idx_q;
`ifdef INIT_TIMEOUT_EN
    assign error          = err_q;
`else
    // Without the watchdog the ERROR state is unreachable.
    assign error          = 1'b0;
    logic unused_err;
    assign unused_err     = err_d;
`endif

endmodule
